// File: rtl/therm_seq_pkg.sv
// Shared types and default widths for the serial thermometer to
// two's-complement sequencer.
//   state_e   : sequencer FSM states
//   TH_LEN_D  : default thermometer bits per code
//   AW_D      : default lookup address / ones-count width
//   DW_D      : default lookup data / result width
package therm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        LOOKUP = 2'd2,
        RESULT = 2'd3
    } state_e;

    localparam int TH_LEN_D = 31;
    localparam int AW_D     = 5;
    localparam int DW_D     = 5;

endpackage : therm_seq_pkg

// File: rtl/therm_ones_counter.sv
// Ones counter for one serially delivered thermometer code.
// Tracks the saturating ones count and the bit index, flags the beat that
// carries the final bit, and (when THERM_CHECK_EN is defined) raises a
// sticky bubble flag when a 1 follows a 0 within the same code.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : clear count/index/flag for a new code
//   beat_i    : a thermometer bit is accepted this cycle
//   bit_i     : the accepted bit value
//   count_o   : ones counted so far (AW bits, saturating)
//   last_o    : this beat carries bit TH_LEN-1
//   err_o     : bubble flag (constant 0 without THERM_CHECK_EN)
module therm_ones_counter #(
    parameter int TH_LEN = 31,
    parameter int AW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          beat_i,
    input  logic          bit_i,
    output logic [AW-1:0] count_o,
    output logic          last_o,
    output logic          err_o
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(TH_LEN - 1);
    localparam logic [AW-1:0] COUNT_MAX = '1;

    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;

    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        if (clr_i) begin
            count_d = '0;
            idx_d   = '0;
        end else if (beat_i) begin
            // Saturation cannot trigger for TH_LEN <= 2**AW-1, but keeps
            // oversize configurations from wrapping to a small count.
            if (bit_i && (count_q != COUNT_MAX))
                count_d = count_q + AW'(1);
            idx_d = idx_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = beat_i && (idx_q == LAST_IDX);

`ifdef THERM_CHECK_EN
    logic seen_zero_q, seen_zero_d;
    logic err_q, err_d;

    always_comb begin
        seen_zero_d = seen_zero_q;
        err_d       = err_q;
        if (clr_i) begin
            seen_zero_d = 1'b0;
            err_d       = 1'b0;
        end else if (beat_i) begin
            if (!bit_i)
                seen_zero_d = 1'b1;
            else if (seen_zero_q)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_zero_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            seen_zero_q <= seen_zero_d;
            err_q       <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule : therm_ones_counter

// File: rtl/therm_twos_comp_seq_ctrl.sv
// Sequencer for the serial thermometer -> two's-complement path.
// Accepts one thermometer code a bit per beat, addresses the external
// lookup memory with the ones count, and returns the memory word on a
// valid/ready result port. Optional bubble checking: THERM_CHECK_EN.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a new code (IDLE only; otherwise dropped)
//   therm_bit    : serial thermometer bit, ones end first
//   therm_valid  : therm_bit qualifier
//   therm_ready  : high in SHIFT
//   rom_addr     : registered lookup address (updated in LOOKUP only)
//   rom_data     : lookup memory read data (combinational read)
//   out_data     : converted value
//   out_valid    : out_data valid, held until out_ready
//   out_ready    : consumer ready
//   busy         : high outside IDLE
//   therm_err    : bubble flag
module therm_twos_comp_seq_ctrl
    import therm_seq_pkg::*;
#(
    parameter int TH_LEN = TH_LEN_D,
    parameter int AW     = AW_D,
    parameter int DW     = DW_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          therm_bit,
    input  logic          therm_valid,
    output logic          therm_ready,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          therm_err
);

    state_e        state_q, state_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    logic          clr;
    logic          beat;
    logic [AW-1:0] count;
    logic          last_beat;

    assign clr  = (state_q == IDLE) && start;
    assign beat = (state_q == SHIFT) && therm_valid;

    therm_ones_counter #(
        .TH_LEN (TH_LEN),
        .AW     (AW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .beat_i  (beat),
        .bit_i   (therm_bit),
        .count_o (count),
        .last_o  (last_beat),
        .err_o   (therm_err)
    );

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = SHIFT;
            end
            SHIFT: begin
                if (last_beat)
                    state_d = LOOKUP;
            end
            LOOKUP: begin
                rom_addr_d = count;
                state_d    = RESULT;
            end
            RESULT: begin
                // out_valid is still low only on the entry cycle, which is
                // when the memory word for the new address is captured.
                if (!out_valid_q) begin
                    out_data_d  = rom_data;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign therm_ready = (state_q == SHIFT);
    assign busy        = (state_q != IDLE);
    assign rom_addr    = rom_addr_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;

endmodule : therm_twos_comp_seq_ctrl

// File: tb/tb_therm_twos_comp_seq_ctrl.sv
// Self-checking bench for therm_twos_comp_seq_ctrl with an attached
// two's-complement lookup memory (mem[i] = -i mod 32).
module tb_therm_twos_comp_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       therm_bit;
    logic       therm_valid;
    logic       therm_ready;
    logic [4:0] rom_addr;
    logic [4:0] rom_data;
    logic [4:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       therm_err;

    logic [4:0] mem [32];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rom_data = mem[rom_addr];

    therm_twos_comp_seq_ctrl #(.TH_LEN(31), .AW(5), .DW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .therm_bit   (therm_bit),
        .therm_valid (therm_valid),
        .therm_ready (therm_ready),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .therm_err   (therm_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: expected result is the two's complement of the number of
    // ones in the code; the bubble flag is set if any 1 follows a 0.
    task automatic run_code(input logic [30:0] code, input int stall_at, input int stall_len,
                            input int hold, input bit pulse);
        int         cnt;
        logic [4:0] exp_out;
        bit         seen0;
        bit         exp_err;
        cnt     = $countones(code);
        exp_out = 5'((32 - cnt) % 32);
        seen0   = 0;
        exp_err = 0;
        for (int i = 0; i < 31; i++) begin
            if (!code[i]) seen0 = 1;
            else if (seen0) exp_err = 1;
        end
`ifndef THERM_CHECK_EN
        exp_err = 0;
`endif
        @(negedge clk);
        start = 1; therm_valid = 0; out_ready = 0;
        @(negedge clk);
        start = 0;
        chk("shift_busy", busy, 1);
        chk("shift_ready", therm_ready, 1);
        chk("err_cleared", therm_err, 0);
        for (int i = 0; i < 31; i++) begin
            if (i == stall_at) begin
                therm_valid = 0;
                therm_bit   = ~code[i];
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_busy", busy, 1);
                    chk("stall_ready", therm_ready, 1);
                end
            end
            therm_bit   = code[i];
            therm_valid = 1;
            start       = pulse && (i == 3);
            @(negedge clk);
            start = 0;
        end
        therm_valid = 0;
        chk("lookup_not_ready", therm_ready, 0);
        chk("lookup_no_valid", out_valid, 0);
        out_ready = (hold == 0);
        @(negedge clk);
        chk("rom_addr", rom_addr, cnt);
        chk("early_valid", out_valid, 0);
        @(negedge clk);
        chk("out_valid_rise", out_valid, 1);
        chk("out_data", out_data, exp_out);
        chk("therm_err", therm_err, exp_err);
        start = pulse;
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, exp_out);
                chk("hold_busy", busy, 1);
            end
            out_ready = 1;
        end
        @(negedge clk);
        start = 0;
        chk("done_valid", out_valid, 0);
        chk("done_idle", busy, 0);
        @(negedge clk);
        chk("start_dropped", busy, 0);
        chk("rom_addr_held", rom_addr, cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [30:0] code;
        int          k;
        for (int i = 0; i < 32; i++) mem[i] = 5'((32 - i) % 32);
        rst = 1; start = 0; therm_bit = 0; therm_valid = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_ready", therm_ready, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", therm_err, 0);
        rst = 0;

        // Reset in the middle of SHIFT discards the conversion.
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 10; i++) begin
            therm_bit = 1; therm_valid = 1;
            @(negedge clk);
        end
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", therm_ready, 0);
        chk("midrst_addr", rom_addr, 0);
        chk("midrst_valid", out_valid, 0);
        for (int i = 0; i < 40; i++) begin
            therm_bit   = 1'($urandom);
            therm_valid = 1;
            @(negedge clk);
            chk("midrst_quiet", {out_valid, busy}, 0);
        end
        therm_valid = 0;

        // Directed codes
        run_code(31'h0000_001F, -1, 0, 0, 0);           // five ones -> 0x1B
        run_code(31'h0000_0000, -1, 0, 0, 0);           // all zero -> 0x00
        run_code(31'h7FFF_FFFF, -1, 0, 0, 0);           // all ones -> 0x01
        run_code(31'h0000_00FF, 12, 7, 4, 0);           // stalls on both sides
        run_code(31'h0000_0007, -1, 0, 3, 1);           // start pulsed while busy
        run_code(31'h0000_0005, -1, 0, 0, 0);           // bubble 1,0,1 -> 0x1E

        // Randomized codes, mostly legal thermometer, some with bubbles
        for (int n = 0; n < 24; n++) begin
            k    = $urandom_range(0, 31);
            code = (k == 31) ? 31'h7FFF_FFFF : 31'((32'd1 << k) - 32'd1);
            if ($urandom_range(0, 3) == 0) code = 31'($urandom);
            run_code(code,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1,
                     int'($urandom_range(1, 8)),
                     int'($urandom_range(0, 5)),
                     bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_therm_twos_comp_seq_ctrl
